multu_hilo_unit: RTL

- Iterative unsigned multiplier with HI/LO registers in the EX stage, downstream of the ALU control decoder.
- Consumes the decoder's mult_enable (MULTU) and sfmux_high/sf2reg (MFHI/MFLO) controls.
- Runs a radix-2 shift-add over WIDTH cycles.
- Returns the selected HI or LO word for writeback and raises a stall to the hazard unit while a product is pending.

---
 rtl/multu_hilo_unit_pkg.sv | 23 ++
 rtl/multu_hilo_unit_if.sv | 32 +++
 rtl/multu_hilo_unit_dp.sv | 52 +++++
 rtl/multu_hilo_unit.sv | 88 ++++++++
 4 files changed

// File: rtl/multu_hilo_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multu_hilo_unit_pkg
// Purpose  : Shared constants and types for the MULTU / HI-LO unit.
// Revision : 1.0 - initial release
// ============================================================================
package multu_hilo_unit_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 6;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // R-type funct codes shared with the ALU control decoder
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;

endpackage
`default_nettype wire

// File: rtl/multu_hilo_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multu_hilo_unit_if
// Purpose  : EX-stage control/data bundle between pipeline and MULTU unit.
// Revision : 1.0 - initial release
// ============================================================================
interface multu_hilo_unit_if #(
   parameter int WIDTH = 32
);
   logic             mult_enable;
   logic             flush;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             mf_req;
   logic             sfmux_high;
   logic             busy;
   logic             stall;
   logic [WIDTH-1:0] hilo_out;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output mult_enable, flush, src_a, src_b, mf_req, sfmux_high,
      input  busy, stall, hilo_out, hi, lo
   );

   modport slave (
      input  mult_enable, flush, src_a, src_b, mf_req, sfmux_high,
      output busy, stall, hilo_out, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/multu_hilo_unit_dp.sv
`default_nettype none
// ============================================================================
// Module   : multu_hilo_unit_dp
// Purpose  : Radix-2 shift-add datapath: accumulator, adder, shifter, counter.
// Revision : 1.0 - initial release
// ============================================================================
module multu_hilo_unit_dp #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   input  wire logic               load_i,
   input  wire logic               step_i,
   input  wire logic [WIDTH-1:0]   mcand_i,
   input  wire logic [WIDTH-1:0]   mplier_i,
   output logic                    count_last_o,
   output logic [2*WIDTH-1:0]      product_o
);

   logic [2*WIDTH:0]   prod_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [CNT_W-1:0]   count_q;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod_shift;

   // Upper half carries its own extra bit so the add never loses a carry
   always_comb begin
      sum        = prod_q[2*WIDTH:WIDTH] + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_shift = {sum, prod_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q  <= '0;
         mcand_q <= '0;
         count_q <= '0;
      end else if (load_i) begin
         mcand_q <= mcand_i;
         prod_q  <= {1'b0, {WIDTH{1'b0}}, mplier_i};
         count_q <= CNT_W'(WIDTH);
      end else if (step_i) begin
         prod_q  <= {1'b0, prod_shift};
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign count_last_o = (count_q == CNT_W'(1));
   assign product_o    = prod_shift;

endmodule
`default_nettype wire

// File: rtl/multu_hilo_unit.sv
`default_nettype none
// ============================================================================
// Module   : multu_hilo_unit
// Purpose  : Iterative unsigned MULTU with HI/LO registers and hazard stall.
// Revision : 1.0 - initial release
// ============================================================================
module multu_hilo_unit
   import multu_hilo_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   multu_hilo_unit_if.slave bus
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               load, step, wr_hilo;
   logic               count_last;
   logic [2*WIDTH-1:0] product;

   multu_hilo_unit_dp #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_dp (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load),
      .step_i       (step),
      .mcand_i      (bus.src_a),
      .mplier_i     (bus.src_b),
      .count_last_o (count_last),
      .product_o    (product)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Flush has priority in both states; a flushed final step never commits
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      wr_hilo = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.mult_enable && !bus.flush) begin
               load    = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.flush) begin
               state_d = ST_IDLE;
            end else begin
               step = 1'b1;
               if (count_last) begin
                  wr_hilo = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (wr_hilo) begin
         hi_q <= product[2*WIDTH-1:WIDTH];
         lo_q <= product[WIDTH-1:0];
      end
   end

   assign bus.busy     = (state_q == ST_RUN);
   assign bus.stall    = bus.busy & (bus.mf_req | bus.mult_enable);
   assign bus.hilo_out = bus.sfmux_high ? hi_q : lo_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule
`default_nettype wire
